fifo_sync_ctrl: RTL
===================

# fifo_sync_ctrl

Single-clock, parametrised FIFO with its own pointer, occupancy and flag logic. It adds full/empty detection, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through read mode. It sits between a producer and a consumer in the same clock domain. It is the same-domain companion to the dual-clock FIFO storage used in asynchronous paths.

## Interface

Parameters:
- DATA_LENGTH, 8, word width in bits
- FIFO_DEPTH, 16, number of entries; power of two, ≥ 2
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- ALMOST_FULL_TH, FIFO_DEPTH-2, almost_full asserted when count ≥ this
- ALMOST_EMPTY_TH, 2, almost_empty asserted when count ≤ this

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- dataIn  in  DATA_LENGTH  write data
- write_enable  in  1  write request
- read_enable  in  1  read/pop request
- clear_flags  in  1  clears sticky overflow/underflow
- dataOut  out  DATA_LENGTH  read data
- full  out  1  count == FIFO_DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ ALMOST_FULL_TH
- almost_empty  out  1  count ≤ ALMOST_EMPTY_TH
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected

## Operation

- Pointers: wr_ptr and rd_ptr, each $clog2(FIFO_DEPTH)+1 bits; the MSB is the wrap bit and the low bits address memory. Both wrap naturally modulo 2·FIFO_DEPTH.
- count = wr_ptr − rd_ptr, modulo the pointer width.
- rd_acc = read_enable && !empty.
- wr_acc = write_enable && (!full || rd_acc). A write while full is accepted only when a read is accepted in the same cycle.
- Simultaneous wr_acc and rd_acc: both pointers advance and count is unchanged. This holds at full as well; at empty only the write is accepted.
- Standard mode (FWFT=0): on rd_acc, dataOut ← mem[rd_ptr] at the next edge. Otherwise dataOut holds.
- FWFT mode (FWFT=1): dataOut = mem[rd_ptr] whenever !empty, and 0 when empty. rd_acc pops the head.
- Error flags:
  - overflow sets on write_enable && !wr_acc.
  - underflow sets on read_enable && empty.
  - Both hold until clear_flags or reset. If a set and a clear occur in the same cycle, set wins.
- Reset (asynchronous assert, synchronous-safe release):
  - pointers 0, count 0
  - empty 1, full 0, almost_empty 1, almost_full 0
  - overflow 0, underflow 0, dataOut 0
  - Memory contents are not reset.
- Reset asserted mid-operation discards all stored words. The FIFO is empty immediately, without waiting for an edge.

## Timing

- All flags and count are registered, computed from next-state pointers. They are valid in the cycle after the causing edge.
- Write to an empty FIFO: empty deasserts one cycle after the write edge.
  - FWFT: dataOut shows the word in that same cycle.
  - Standard: read_enable is accepted from that cycle, and data appears one cycle after rd_acc.
- Read latency: standard mode 1 cycle; FWFT mode 0 cycles.
- The last read (count 1→0) raises empty in the next cycle. A read_enable in that cycle sets underflow.
- full rises one cycle after the write that fills the FIFO.
- Threshold flags track count with no extra hysteresis.

## Structure

- Package fifo_pkg:
  - function ptr_width(depth) = $clog2(depth)+1
  - FIFO mode enum: STD, FWFT
  - Shared by the async FIFO variants.
- Sub-module fifo_sync_mem: FIFO_DEPTH × DATA_LENGTH array with a synchronous write port and an asynchronous read port. It has no reset. The controller owns all pointer, flag and output-register logic.
- Parameter checks at elaboration:
  - FIFO_DEPTH is a power of two.
  - 0 ≤ ALMOST_EMPTY_TH < ALMOST_FULL_TH ≤ FIFO_DEPTH.

## Test plan

- Reset release, then write 16 words 0x00..0x0F (DEPTH=16): full rises after the 16th write edge; almost_full rises when count reaches 14; count = 16.
- Write to full, then 16 reads (standard mode): dataOut = 0x00..0x0F, each one cycle after its rd_acc; empty rises after the last read; no error flags.
- Full FIFO with write_enable and read_enable together for 20 cycles: count stays at 16 and no overflow. Then write only: overflow sets and stays set until a clear_flags pulse.
- Empty FIFO with read_enable: underflow sets and dataOut holds 0. Simultaneous write+read at empty: the write is accepted, the read rejected, and count = 1.
- FWFT=1: write 0xA5 to empty; the next cycle empty=0 and dataOut=0xA5 with no read. Pop: empty=1 and dataOut=0.
- Write 20 and read 20 interleaved across the pointer wrap: data order preserved and count correct. Assert reset mid-stream: empty=1 and count=0 immediately.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: pointer sizing, read-mode
// selection and small parameter helpers.
package fifo_pkg;

    // Read-side behaviour of a FIFO instance.
    typedef enum logic {
        STD  = 1'b0,   // registered read, one cycle of latency
        FWFT = 1'b1    // head word presented without a read request
    } fifo_mode_e;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // True when value is a non-zero power of two.
    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// FIFO storage array: synchronous write port, asynchronous read port.
// The array is never reset; stale words are masked by the controller's
// pointers.
module fifo_sync_mem
    import fifo_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int FIFO_DEPTH  = 16,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                   clk,
    input  logic                   i_wr_en,
    input  logic [AW-1:0]          i_wr_addr,
    input  logic [DATA_LENGTH-1:0] i_wr_data,
    input  logic [AW-1:0]          i_rd_addr,
    output logic [DATA_LENGTH-1:0] o_rd_data
);

    logic [DATA_LENGTH-1:0] r_mem [FIFO_DEPTH];

    // Store the incoming word at the write address on an accepted write.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // The head word is read combinationally so the controller can either
    // register it (standard mode) or present it directly (FWFT mode).
    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy, full/empty and
// threshold flags, sticky error flags and the read-data path for either
// standard or first-word-fall-through mode.
module fifo_sync_ctrl #(
    parameter int DATA_LENGTH     = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int FWFT            = 0,
    parameter int ALMOST_FULL_TH  = FIFO_DEPTH - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [DATA_LENGTH-1:0]                    dataIn,
    input  logic                                      write_enable,
    input  logic                                      read_enable,
    input  logic                                      clear_flags,
    output logic [DATA_LENGTH-1:0]                    dataOut,
    output logic                                      full,
    output logic                                      empty,
    output logic                                      almost_full,
    output logic                                      almost_empty,
    output logic [fifo_pkg::ptr_width(FIFO_DEPTH)-1:0] count,
    output logic                                      overflow,
    output logic                                      underflow
);

    import fifo_pkg::*;

    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam int AW = PW - 1;

    // The integer mode parameter is folded into the package enum once here.
    localparam fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;

    localparam logic [PW-1:0] DEPTH_C = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] AF_C    = PW'(ALMOST_FULL_TH);
    localparam logic [PW-1:0] AE_C    = PW'(ALMOST_EMPTY_TH);
    localparam logic [PW-1:0] ONE_C   = PW'(1);
    localparam logic [PW-1:0] ZERO_C  = '0;

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_ctrl: FIFO_DEPTH must be a power of two and at least 2");
    end

    if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH >= ALMOST_FULL_TH ||
        ALMOST_FULL_TH > FIFO_DEPTH) begin : g_bad_thresholds
        $error("fifo_sync_ctrl: need 0 <= ALMOST_EMPTY_TH < ALMOST_FULL_TH <= FIFO_DEPTH");
    end

    if (FWFT != 0 && FWFT != 1) begin : g_bad_mode
        $error("fifo_sync_ctrl: FWFT must be 0 or 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_almost_full;
    logic          r_almost_empty;
    logic          r_overflow;
    logic          r_underflow;

    logic                   w_rd_acc;
    logic                   w_wr_acc;
    logic [PW-1:0]          w_wr_ptr_next;
    logic [PW-1:0]          w_rd_ptr_next;
    logic [PW-1:0]          w_count_next;
    logic                   w_full_next;
    logic                   w_empty_next;
    logic                   w_almost_full_next;
    logic                   w_almost_empty_next;
    logic                   w_overflow_next;
    logic                   w_underflow_next;
    logic [DATA_LENGTH-1:0] w_rd_data;

    // Accept logic, next-state pointers and the flags derived from them.
    // A write at full is only taken when a read frees a slot in the same
    // cycle; at empty no read is ever taken, so a paired write goes alone.
    always_comb begin
        w_rd_acc = read_enable && !r_empty;
        w_wr_acc = write_enable && (!r_full || w_rd_acc);

        w_wr_ptr_next = w_wr_acc ? (r_wr_ptr + ONE_C) : r_wr_ptr;
        w_rd_ptr_next = w_rd_acc ? (r_rd_ptr + ONE_C) : r_rd_ptr;

        // Modulo-2*DEPTH difference; the wrap bit disambiguates full/empty.
        w_count_next = w_wr_ptr_next - w_rd_ptr_next;

        w_full_next         = (w_count_next == DEPTH_C);
        w_empty_next        = (w_count_next == ZERO_C);
        w_almost_full_next  = (w_count_next >= AF_C);
        w_almost_empty_next = (w_count_next <= AE_C);

        // Sticky errors: a set in the same cycle as a clear takes priority.
        w_overflow_next = r_overflow;
        if (clear_flags) begin
            w_overflow_next = 1'b0;
        end
        if (write_enable && !w_wr_acc) begin
            w_overflow_next = 1'b1;
        end

        w_underflow_next = r_underflow;
        if (clear_flags) begin
            w_underflow_next = 1'b0;
        end
        if (read_enable && r_empty) begin
            w_underflow_next = 1'b1;
        end
    end

    // Pointer, occupancy and flag registers; reset empties the FIFO at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_next;
            r_rd_ptr       <= w_rd_ptr_next;
            r_count        <= w_count_next;
            r_full         <= w_full_next;
            r_empty        <= w_empty_next;
            r_almost_full  <= w_almost_full_next;
            r_almost_empty <= w_almost_empty_next;
            r_overflow     <= w_overflow_next;
            r_underflow    <= w_underflow_next;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    fifo_sync_mem #(
        .DATA_LENGTH (DATA_LENGTH),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (dataIn),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    // ------------------------------------------------------------------
    // Read-data path
    // ------------------------------------------------------------------
    if (MODE == fifo_pkg::STD) begin : g_std
        logic [DATA_LENGTH-1:0] r_data_out;

        // Capture the head word on each accepted read; hold otherwise.
        // When a read and a write to the same slot coincide (at full), the
        // array still returns the old word at this edge.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_data_out <= '0;
            end else if (w_rd_acc) begin
                r_data_out <= w_rd_data;
            end
        end

        assign dataOut = r_data_out;
    end else begin : g_fwft
        // Head word is visible whenever the FIFO holds data; zero when empty.
        assign dataOut = r_empty ? '0 : w_rd_data;
    end

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
